// File: rtl/cpu_io_sequencer.sv
// Run controller and FWFT output buffer for the 36-bit CPU core.
// Optional watchdog: define CPU_IO_SEQ_WATCHDOG_EN.
module cpu_io_sequencer #(
  parameter int WIDTH       = 36,
  parameter int DEPTH       = 8,
  parameter int BOOT_CYCLES = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startIO,
  input  logic             cpuOutFlag,
  input  logic [WIDTH-1:0] cpuOut,
  input  logic             cpuHalt,
  output logic             cpuReset,
  output logic             cpuStall,
  output logic             outValid,
  output logic [WIDTH-1:0] outData,
  input  logic             outReady,
  output logic             running,
  output logic             overflow,
  output logic             timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [AW:0] CNT_ZERO   = (AW+1)'(0);
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ALMOST = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_start;
  logic [BW-1:0]    r_boot_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_pop;
  logic             w_capture;
  logic             w_push;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_pop     = (r_count != CNT_ZERO) && outReady;
  assign w_capture = cpuOutFlag && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_push    = w_capture && ((r_count != CNT_FULL) || w_pop);

  assign cpuReset = (r_state == S_IDLE) || (r_state == S_BOOT);
  assign running  = (r_state == S_RUN);
  assign cpuStall = ((r_state == S_RUN) && (r_count >= CNT_ALMOST)) ||
                    (r_state == S_DRAIN) || (r_state == S_DONE);
  assign outValid = (r_count != CNT_ZERO);
  assign outData  = outValid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
  assign overflow = r_overflow;

`ifdef CPU_IO_SEQ_WATCHDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WW-1:0] r_wdog_cnt;
  logic          r_timeout;
  logic          w_wdog_fire;

  assign w_wdog_fire = (r_wdog_cnt == WW'(WDOG_CYCLES - 1)) && !w_push;
  assign timeout     = r_timeout;

  // Watchdog counts RUN cycles since the last accepted push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt <= {WW{1'b0}};
    end else if ((r_state != S_RUN) || w_push) begin
      r_wdog_cnt <= {WW{1'b0}};
    end else begin
      r_wdog_cnt <= r_wdog_cnt + WW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Run-control state machine; the switch is registered once before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_start    <= 1'b0;
      r_boot_cnt <= {BW{1'b0}};
`ifdef CPU_IO_SEQ_WATCHDOG_EN
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_start <= startIO;
      case (r_state)
        S_IDLE: begin
          if (r_start) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= {BW{1'b0}};
          end
        end
        S_BOOT: begin
          if (!r_start) begin
            r_state <= S_IDLE;
          end else if (r_boot_cnt == BW'(BOOT_CYCLES - 1)) begin
            r_state <= S_RUN;
          end else begin
            r_boot_cnt <= r_boot_cnt + BW'(1);
          end
        end
        S_RUN: begin
          if (cpuHalt || !r_start) begin
            r_state <= S_DRAIN;
`ifdef CPU_IO_SEQ_WATCHDOG_EN
          end else if (w_wdog_fire) begin
            r_timeout <= 1'b1;
            r_state   <= S_DRAIN;
`endif
          end
        end
        S_DRAIN: begin
          if (r_count == CNT_ZERO) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!r_start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= CNT_ZERO;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_capture && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cpuOut;
    end
  end

endmodule

// File: doc/cpu_io_sequencer.md
# cpu_io_sequencer

Run controller and output buffer for the 36-bit CPU core. It holds the CPU in reset until the `startIO` switch is raised, then releases it after a fixed boot interval. While the CPU runs, every word strobed on its output port is captured into a first-word-fall-through FIFO and drained to a downstream consumer over a valid/ready handshake. When the FIFO nears capacity the CPU is stalled, and on halt or switch-off the remaining words are drained.

## Interface
Clock `clk`; reset `reset` is synchronous and active-high.

Parameters:
- `WIDTH`, 36: CPU output word width.
- `DEPTH`, 8: FIFO entries; power of two, at least 4.
- `BOOT_CYCLES`, 2: cycles `cpuReset` stays high after start.
- `WDOG_CYCLES`, 1024: watchdog limit (see Configuration).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high block reset.
- `startIO` in 1: run switch, level-sensitive.
- `cpuOutFlag` in 1: CPU output strobe, one word per high cycle.
- `cpuOut` in `WIDTH`: CPU output word.
- `cpuHalt` in 1: CPU finished, level.
- `cpuReset` out 1: reset driven to the CPU.
- `cpuStall` out 1: stalls the CPU pipeline.
- `outValid` out 1: FIFO head is valid.
- `outData` out `WIDTH`: FIFO head word.
- `outReady` in 1: consumer accepts the head word.
- `running` out 1: high in RUN.
- `overflow` out 1: sticky; a strobe was dropped.
- `timeout` out 1: sticky; the watchdog fired (0 when compiled out).

## Operation
- Reset values: state IDLE, `cpuReset`=1, `cpuStall`=0, `outValid`=0, `outData`=0, `running`=0, `overflow`=0, `timeout`=0. FIFO count=0, pointers=0.
- **IDLE**:
  - `cpuReset`=1.
  - `startIO`=1 moves to BOOT with the boot counter cleared.
- **BOOT**:
  - `cpuReset`=1 and the counter increments.
  - After exactly `BOOT_CYCLES` cycles in BOOT, move to RUN.
  - `startIO`=0 returns to IDLE.
- **RUN**:
  - `cpuReset`=0, `running`=1.
  - `cpuStall` = (count >= DEPTH-1), decoded from the registered count.
  - `cpuHalt`=1 or `startIO`=0 moves to DRAIN. Halt wins if both are true; the result is the same.
- **DRAIN**:
  - `cpuStall`=1, `cpuReset`=0.
  - Strobes are still captured while space remains.
  - Count==0 moves to DONE.
- **DONE**:
  - `cpuStall`=1.
  - `startIO`=0 moves to IDLE, where the CPU is reset again.
  - A restart requires a 0→1 cycle on `startIO`.
- **FIFO push** happens on `cpuOutFlag`=1 in RUN or DRAIN when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set until `reset`.
  - Strobes in IDLE, BOOT and DONE are ignored and do not set `overflow`.
- **FIFO pop** happens on `outValid`&&`outReady`.
  - `outValid` = (count != 0).
  - `outData` = head entry when valid, else 0.
- **Simultaneous push and pop** leaves count unchanged and advances both pointers.
- **Pointers** are log2(`DEPTH`) bits and wrap modulo `DEPTH`. The count is log2(`DEPTH`)+1 bits.
- **Reset mid-operation**: any state goes to IDLE, the FIFO is flushed, the sticky flags clear, and `cpuReset` is 1 on the next edge.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from `outReady`, `cpuOutFlag` or `cpuHalt` to any output.
- **Start to release**: `startIO` is sampled high at edge N. BOOT is entered at N+1, and `cpuReset` falls after edge N+1+`BOOT_CYCLES`.
- **Push latency**: a word strobed at edge N appears on `outData`/`outValid` after edge N (one cycle).
- **Stall latency**:
  - `cpuStall` rises the cycle after count reaches DEPTH-1.
  - The CPU may issue one more strobe in that cycle, which fills the last entry without loss.
- **Pop**: the next head is presented the cycle after the accepting edge.

## Configuration
- **`CPU_IO_SEQ_WATCHDOG_EN` defined**:
  - In RUN, a counter clears on every accepted push and otherwise increments.
  - On reaching `WDOG_CYCLES`, the block sets `timeout` (sticky) and moves to DRAIN.
- **`CPU_IO_SEQ_WATCHDOG_EN` undefined**:
  - No counter is instantiated and `timeout` is tied to 0.
  - RUN exits only on `cpuHalt` or `startIO`=0.

## Test plan
- **Boot**: reset 2 cycles, then `startIO`=1 → `cpuReset` stays 1 for exactly 2 cycles after BOOT entry, then 0; `running`=1.
- **Stream**:
  - Stimulus: `outReady`=1, strobes of 0x000000001…0x000000005 on consecutive cycles.
  - Required: each word appears one cycle later, in order; `cpuStall` never asserts.
- **Backpressure**:
  - Stimulus: `outReady`=0, strobe 8 words whenever `cpuStall`=0.
  - Required: `cpuStall` rises after 7 pushes; the 8th word is held; `overflow`=0.
  - Then force a 9th strobe → `overflow`=1 and count stays 8.
- **Full with push and pop**: at count=8, with `outReady`=1 and a strobe in the same cycle → count stays 8, the new word is queued at the tail, and `overflow`=0.
- **Halt and drain**:
  - Stimulus: `cpuHalt`=1 with 3 words queued, `outReady`=1.
  - Required: DRAIN with `cpuStall`=1; 3 words drained; DONE; `startIO`=0 → IDLE with `cpuReset`=1.
- **Watchdog** (macro on, `WDOG_CYCLES`=16): in RUN with no strobes → after 16 cycles `timeout`=1, then DRAIN, then DONE.
  - Mid-run `reset` pulse → all flags 0 and IDLE.
